muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
// Sequencer for the multicycle mult/div units and the HI/LO register pair.
// - The main control FSM issues a one-cycle start with an opcode select.
// - This block launches the mult or div unit and counts its fixed latency.
// - On completion it writes HI/LO; a zero divisor raises the exception flag instead.
// - Main control stalls on busy and resumes on done or div_zero_exc.
// PARAMETERS
// MULT_CYCLES  32  mult unit latency in cycles, from the MultCtrl pulse until results are valid
// DIV_CYCLES   32  div unit latency in cycles, from the DivCtrl pulse until results are valid
// CNT_W        6   counter width; must satisfy 2**CNT_W > max(MULT_CYCLES, DIV_CYCLES)
// PORTS
// clk           in   1   system clock, rising edge
// reset         in   1   asynchronous, active-low reset
// start         in   1   one-cycle request from main control; sampled only in IDLE
// op            in   1   0 = mult, 1 = div; sampled with start
// b_in          in   32  divisor (B register), sampled with start when op=1
// abort         in   1   synchronous cancel; returns to IDLE with no HI/LO write
// mult_ctrl     out  1   one-cycle launch pulse to the mult unit
// div_ctrl      out  1   one-cycle launch pulse to the div unit
// hi_src        out  1   HI mux select: 0 = mult result, 1 = div result
// lo_src        out  1   LO mux select: 0 = mult result, 1 = div result
// hilo_write    out  1   HI/LO write enable
// busy          out  1   high in every state except IDLE
// done          out  1   one-cycle completion pulse; HI/LO are written in the same cycle
// div_zero_exc  out  1   one-cycle divide-by-zero exception pulse to main control
// BEHAVIOUR
// - Reset: when reset=0, the FSM goes to IDLE immediately, regardless of clk.
//   All outputs are 0, the counter is 0 and the latched op is 0.
// - States: IDLE, MULT_RUN, DIV_RUN, WRITE, EXC. Outputs are Moore-decoded from registered state.
// - IDLE, start=1, op=0: go to MULT_RUN; load counter with MULT_CYCLES-1; latch op=0.
// - IDLE, start=1, op=1, b_in!=0: go to DIV_RUN; load counter with DIV_CYCLES-1; latch op=1.
// - IDLE, start=1, op=1, b_in==0: go to EXC. No unit is launched and HI/LO are untouched.
// - RUN states:
//   - The counter decrements once per cycle.
//   - When the counter reaches 0, the next state is WRITE.
//   - Each RUN state therefore lasts exactly N cycles.
// - Launch pulses: mult_ctrl (MULT_RUN) or div_ctrl (DIV_RUN) is high only in the first RUN
//   cycle, identified as counter == N-1.
// - WRITE: hilo_write=1 and done=1 for one cycle, then IDLE.
// - EXC: div_zero_exc=1 for one cycle; done stays 0; then IDLE.
// - hi_src and lo_src both equal the latched op.
//   - They are held from the first RUN cycle through WRITE.
//   - They keep their value in IDLE and change only on the next accepted start.
// - Latency: start accepted at edge T gives done=1 in cycle T+N+1 (N = MULT_CYCLES or DIV_CYCLES).
//   Divide-by-zero gives div_zero_exc=1 in cycle T+1.
// - start while busy is ignored: no queueing and no state change.
// - abort=1:
//   - In MULT_RUN or DIV_RUN: IDLE at the next edge; no hilo_write, no done.
//   - In IDLE together with start: abort wins and the request is dropped.
//   - In WRITE or EXC: no effect, since the next state is IDLE anyway.
// - start sampled in the WRITE or EXC cycle is ignored. Back-to-back ops need one IDLE
//   cycle, i.e. the earliest restart is the cycle after done.
// - Counter arithmetic is unsigned CNT_W-bit. With N=1 the counter is loaded with 0 and the
//   RUN state lasts one cycle; the counter never wraps.
// - Reset deasserted mid-operation (async assert then release): the block restarts from IDLE.
//   HI/LO are not written; the main FSM must reissue start.
// - Invariants:
//   - At most one of mult_ctrl, div_ctrl, hilo_write and div_zero_exc is high in any cycle.
//   - done implies hilo_write.
// TESTING
// 1. start=1, op=0 at T (MULT_CYCLES=32): mult_ctrl=1 only at T+1; busy=1 over T+1..T+33;
//    hilo_write=done=1 only at T+33; hi_src=lo_src=0.
// 2. start=1, op=1, b_in=7: div_ctrl pulses once at T+1; done at T+33; hi_src=lo_src=1;
//    mult_ctrl never asserted.
// 3. start=1, op=1, b_in=0: div_zero_exc=1 at T+1 only; hilo_write, done, div_ctrl stay 0;
//    busy=0 from T+2.
// 4. In DIV_RUN at counter=10, start=1, op=0: ignored; done still arrives at T+33 with
//    hi_src=1. Separately, abort=1 at counter=5: busy=0 next cycle and no done ever.
// 5. Pull reset low asynchronously mid-MULT_RUN: all outputs 0 with no clk edge; after
//    release, start op=1 b_in=3 completes normally in 33 cycles.
// 6. Back-to-back: a second start in the cycle after done is accepted; a start on the done
//    cycle itself is ignored. Assert the one-hot invariant every cycle.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between the main control FSM and the mult/div sequencer,
// including the launch, HI/LO write and exception lines the sequencer drives.
interface muldiv_ctrl_if;
    logic        start;
    logic        op;
    logic [31:0] b_in;
    logic        abort;
    logic        mult_ctrl;
    logic        div_ctrl;
    logic        hi_src;
    logic        lo_src;
    logic        hilo_write;
    logic        busy;
    logic        done;
    logic        div_zero_exc;

    modport master (
        output start, op, b_in, abort,
        input  mult_ctrl, div_ctrl, hi_src, lo_src, hilo_write, busy, done, div_zero_exc
    );

    modport slave (
        input  start, op, b_in, abort,
        output mult_ctrl, div_ctrl, hi_src, lo_src, hilo_write, busy, done, div_zero_exc
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multicycle mult/div units: launches a unit, counts its fixed
// latency, then writes HI/LO, or flags divide-by-zero without launching anything.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_ctrl_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MULT_RUN = 3'd1,
        S_DIV_RUN  = 3'd2,
        S_WRITE    = 3'd3,
        S_EXC      = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             mult_ctrl_q, mult_ctrl_d;
    logic             div_ctrl_q, div_ctrl_d;
    logic             hilo_write_q, hilo_write_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_exc_q, div_zero_exc_d;

    // Next-state, latency counter and latched-op logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                // abort outranks a coincident start: the request is simply dropped
                if (bus.start && !bus.abort) begin
                    if (!bus.op) begin
                        state_d = S_MULT_RUN;
                        cnt_d   = MULT_LOAD;
                        op_d    = 1'b0;
                    end else if (bus.b_in != 32'd0) begin
                        state_d = S_DIV_RUN;
                        cnt_d   = DIV_LOAD;
                        op_d    = 1'b1;
                    end else begin
                        state_d = S_EXC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MULT_RUN, S_DIV_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WRITE, S_EXC: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                op_d    = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so the outputs leave a flop in the state's own cycle
    always_comb begin
        mult_ctrl_d    = 1'b0;
        div_ctrl_d     = 1'b0;
        hilo_write_d   = 1'b0;
        done_d         = 1'b0;
        div_zero_exc_d = 1'b0;
        busy_d         = 1'b1;
        case (state_d)
            S_IDLE:     busy_d = 1'b0;
            S_MULT_RUN: mult_ctrl_d = (cnt_d == MULT_LOAD);
            S_DIV_RUN:  div_ctrl_d  = (cnt_d == DIV_LOAD);
            S_WRITE: begin
                hilo_write_d = 1'b1;
                done_d       = 1'b1;
            end
            S_EXC:      div_zero_exc_d = 1'b1;
            default:    busy_d = 1'b0;
        endcase
    end

    // State, counter, latched op and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= CNT_ZERO;
            op_q           <= 1'b0;
            mult_ctrl_q    <= 1'b0;
            div_ctrl_q     <= 1'b0;
            hilo_write_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            div_zero_exc_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            op_q           <= op_d;
            mult_ctrl_q    <= mult_ctrl_d;
            div_ctrl_q     <= div_ctrl_d;
            hilo_write_q   <= hilo_write_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            div_zero_exc_q <= div_zero_exc_d;
        end
    end

    // HI and LO always come from the same unit, so both selects follow the latched op
    assign bus.hi_src       = op_q;
    assign bus.lo_src       = op_q;
    assign bus.mult_ctrl    = mult_ctrl_q;
    assign bus.div_ctrl     = div_ctrl_q;
    assign bus.hilo_write   = hilo_write_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.div_zero_exc = div_zero_exc_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table plus hand-written corner sequences,
// with a scoreboard of expected done/exception events checked by a cycle monitor.
module tb_muldiv_ctrl;

    localparam int N_MULT = 32;
    localparam int N_DIV  = 32;

    logic clk;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;

    // monitor tallies, written only by the monitor process
    int   n_mult, n_div, n_busy, n_hw, n_done, n_exc;
    int   last_launch_cyc;

    typedef struct {
        int   kind;   // 1 = done, 2 = div_zero_exc
        int   cyc;
        logic src;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        op;
        logic [31:0] b;
        int          kind;
        int          mult_pulses;
        int          div_pulses;
        int          busy_cycles;
        int          hw_cycles;
    } vec_t;

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // per-cycle monitor: invariants, tallies and scoreboard pops
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            chk("onehot", 32'($countones({bus.mult_ctrl, bus.div_ctrl, bus.hilo_write, bus.div_zero_exc}) <= 1), 32'd1);
            chk("done_implies_hw", 32'(!bus.done || bus.hilo_write), 32'd1);
            if (bus.mult_ctrl)    n_mult++;
            if (bus.div_ctrl)     n_div++;
            if (bus.busy)         n_busy++;
            if (bus.hilo_write)   n_hw++;
            if (bus.done)         n_done++;
            if (bus.div_zero_exc) n_exc++;
            if (bus.mult_ctrl || bus.div_ctrl) last_launch_cyc = cyc;
            if (bus.done || bus.div_zero_exc) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("evt_kind", bus.done ? 32'd1 : 32'd2, 32'(e.kind));
                    chk("evt_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.kind == 1) chk("evt_src", {30'd0, bus.hi_src, bus.lo_src}, {30'd0, e.src, e.src});
                end
            end
        end
    end

    task automatic issue(input logic o, input logic [31:0] b, input logic ab, input int kind, output int t);
        exp_t e;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = o;
        bus.b_in  = b;
        bus.abort = ab;
        t = cyc;
        if (kind != 0) begin
            e.kind = kind;
            e.cyc  = (kind == 2) ? t + 1 : t + (o ? N_DIV : N_MULT) + 1;
            e.src  = o;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("wait_idle_timeout", 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    vec_t vecs[6];
    int   t, t2;
    int   s_mult, s_div, s_busy, s_hw, s_done;

    initial begin
        cyc = 0; n_tests = 0; n_fail = 0;
        n_mult = 0; n_div = 0; n_busy = 0; n_hw = 0; n_done = 0; n_exc = 0;
        last_launch_cyc = -1;
        bus.start = 1'b0; bus.op = 1'b0; bus.b_in = 32'd0; bus.abort = 1'b0;
        reset = 1'b0;

        vecs[0] = '{1'b0, 32'd0,          1, 1, 0, 33, 1};
        vecs[1] = '{1'b0, 32'd5,          1, 1, 0, 33, 1};
        vecs[2] = '{1'b1, 32'd7,          1, 0, 1, 33, 1};
        vecs[3] = '{1'b1, 32'd0,          2, 0, 0, 1,  0};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF,  1, 0, 1, 33, 1};
        vecs[5] = '{1'b0, 32'd1,          1, 1, 0, 33, 1};

        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {24'd0, bus.mult_ctrl, bus.div_ctrl, bus.hi_src, bus.lo_src,
                              bus.hilo_write, bus.busy, bus.done, bus.div_zero_exc}, 32'd0);
        @(negedge clk); #1;
        reset = 1'b1;

        // vector table
        for (int i = 0; i < 6; i++) begin
            s_mult = n_mult; s_div = n_div; s_busy = n_busy; s_hw = n_hw;
            issue(vecs[i].op, vecs[i].b, 1'b0, vecs[i].kind, t);
            wait_idle();
            repeat (2) @(negedge clk);
            chk("mult_pulses", 32'(n_mult - s_mult), 32'(vecs[i].mult_pulses));
            chk("div_pulses",  32'(n_div - s_div),   32'(vecs[i].div_pulses));
            chk("busy_cycles", 32'(n_busy - s_busy), 32'(vecs[i].busy_cycles));
            chk("hw_cycles",   32'(n_hw - s_hw),     32'(vecs[i].hw_cycles));
            if (vecs[i].kind == 1) chk("launch_cycle", 32'(last_launch_cyc), 32'(t + 1));
        end

        // start while in DIV_RUN at counter 10 is ignored
        s_mult = n_mult;
        issue(1'b1, 32'd7, 1'b0, 1, t);
        repeat (21) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 1'b0; bus.b_in = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();
        chk("busy_start_ignored_mult", 32'(n_mult - s_mult), 32'd0);

        // abort in DIV_RUN at counter 5
        s_done = n_done; s_hw = n_hw;
        issue(1'b1, 32'd7, 1'b0, 0, t);
        repeat (26) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(n_done - s_done), 32'd0);
        chk("abort_no_hw", 32'(n_hw - s_hw), 32'd0);

        // abort together with start in IDLE drops the request
        s_mult = n_mult; s_div = n_div;
        issue(1'b1, 32'd4, 1'b1, 0, t);
        @(negedge clk);
        chk("abort_start_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_start_pulses", 32'(n_mult - s_mult + n_div - s_div), 32'd0);

        // asynchronous reset mid-MULT_RUN, then a normal divide
        issue(1'b0, 32'd0, 1'b0, 0, t);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", {24'd0, bus.mult_ctrl, bus.div_ctrl, bus.hi_src, bus.lo_src,
                                    bus.hilo_write, bus.busy, bus.done, bus.div_zero_exc}, 32'd0);
        @(negedge clk); #1;
        reset = 1'b1;
        s_div = n_div;
        issue(1'b1, 32'd3, 1'b0, 1, t);
        wait_idle();
        chk("post_reset_div_pulses", 32'(n_div - s_div), 32'd1);

        // back-to-back: start on the done cycle ignored, start one cycle later accepted
        s_mult = n_mult; s_div = n_div; s_done = n_done;
        issue(1'b0, 32'd0, 1'b0, 1, t);
        repeat (32) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 1'b1; bus.b_in = 32'd9;
        @(posedge clk); #1;
        t2 = cyc;
        sb.push_back('{1, t2 + N_DIV + 1, 1'b1});
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();
        chk("b2b_launch_cycle", 32'(last_launch_cyc), 32'(t2 + 1));
        chk("b2b_pulses", 32'(n_mult - s_mult + n_div - s_div), 32'd2);
        chk("b2b_dones", 32'(n_done - s_done), 32'd2);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
